binary_to_str: RTL and testbench
================================

BINARY_TO_STR -- requirements
Module: binary_to_str

Interface
REQ-001 Port list SHALL be, in positional order: in, CLK, out, RST (existing instantiations bind the first three positionally).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 in  input  512  binary data as 64 bytes; byte 0 = in[511:504], byte k = in[511-8k -: 8].
REQ-005 out  output  1536  ASCII decimal text as 64 three-character groups; group k = out[1535-24k -: 24].
REQ-006 No parameters; widths fixed at 512 in / 1536 out.

Function
REQ-007 Each input byte k (unsigned, 0..255) SHALL be converted to exactly three ASCII decimal digits, zero-padded, hundreds first.
REQ-008 Digit encoding SHALL be 8'h30 + digit value; within group k, hundreds = out[1535-24k -: 8], tens = next 8 bits, units = lowest 8 bits.
REQ-009 Byte-to-group mapping SHALL be order-preserving: byte k maps to group k, never reversed.
REQ-010 Binary-to-decimal conversion SHALL be combinational per byte (double-dabble or compare/subtract); no multi-cycle iteration.
REQ-011 out SHALL be registered; latency is exactly 1 cycle: the value of in sampled at rising edge N appears on out after edge N and holds until edge N+1.
REQ-012 No handshake; a new conversion occurs every cycle, including when in is unchanged.
REQ-013 Boundaries: 8'h00 -> "000" (24'h303030); 8'hFF -> "255" (24'h323535); 8'h64 -> "100" (24'h313030); 8'h09 -> "009" (24'h303039).
REQ-014 Every out byte outside reset SHALL lie in 8'h30..8'h39; the hundreds digit SHALL never exceed 8'h32.
REQ-015 X/Z on in is not handled; behaviour for undefined inputs is unspecified.

Reset
REQ-016 While RST=1 at a rising edge, out SHALL become 1536'b0 on that edge, overriding in.
REQ-017 On the first rising edge with RST=0, out SHALL load the conversion of the current in; no further recovery cycles.
REQ-018 Assertion of RST in mid-stream SHALL discard the pending result; there is no other internal state.

Structure
REQ-019 Shared package SHALL hold: DATA_W=512, NUM_BYTES=64, OUT_W=1536, CHAR_W=8, ASCII_ZERO=8'h30.
REQ-020 Sub-module byte_to_dec3 (8-bit in, 24-bit ASCII out, purely combinational) SHALL be instantiated 64 times via generate.
REQ-021 The top level SHALL contain only the generate loop and the single 1536-bit output register with synchronous reset.

Verification
REQ-022 RST=1 for 2 cycles with any in -> out==0; after release, one edge -> converted value present.
REQ-023 in = ASCII "Hello my name is Leah ..." (512-bit string, byte0=8'h48, byte63=8'h29) -> out[1535:1512]=24'h303732 ("072"), out[23:0]=24'h303431 ("041"), one cycle after sampling.
REQ-024 in = all 8'h00 -> out = 64 repetitions of 24'h303030; in = all 8'hFF -> 64 repetitions of 24'h323535.
REQ-025 in byte k = k (k=0..63) -> group k equals zero-padded decimal of k (group 0 "000", group 10 "010", group 63 "063"), proving ordering.
REQ-026 Exhaustive: sweep byte 0 through 0..255 with other bytes fixed -> group 0 matches reference decimal, other groups unchanged; change in every cycle -> out tracks with exactly one-cycle lag.
REQ-027 Assert RST mid-sweep for 1 cycle -> out==0 on that edge, correct conversion resumes on the next edge.

Source files
------------

// File: rtl/binary_to_str_pkg.sv
// Shared widths and ASCII constants for the 512-bit binary to 1536-bit decimal text converter.
package binary_to_str_pkg;
    localparam int DATA_W     = 512;
    localparam int NUM_BYTES  = 64;
    localparam int OUT_W      = 1536;
    localparam int CHAR_W     = 8;
    localparam int GROUP_W    = 3 * CHAR_W;
    localparam logic [CHAR_W-1:0] ASCII_ZERO = 8'h30;
endpackage

// File: rtl/binary_to_str_byte_to_dec3.sv
// Combinational byte to three zero-padded ASCII decimal digits, hundreds first.
module byte_to_dec3
    import binary_to_str_pkg::*;
(
    input  logic [CHAR_W-1:0]  val,
    output logic [GROUP_W-1:0] ascii
);

    logic [1:0] hund;
    logic [3:0] tens;
    logic [7:0] rem;
    logic [7:0] low;

    // Compare/subtract: strip hundreds first, then pick the largest multiple of ten that fits.
    always_comb begin
        hund = 2'd0;
        rem  = val;
        if (val >= 8'd200) begin
            hund = 2'd2;
            rem  = val - 8'd200;
        end else if (val >= 8'd100) begin
            hund = 2'd1;
            rem  = val - 8'd100;
        end
        tens = 4'd0;
        low  = rem;
        for (int d = 9; d >= 1; d--) begin
            if (tens == 4'd0 && rem >= 8'(d * 10)) begin
                tens = 4'(d);
                low  = rem - 8'(d * 10);
            end
        end
        ascii = {ASCII_ZERO + {6'd0, hund},
                 ASCII_ZERO + {4'd0, tens},
                 ASCII_ZERO + low};
    end

endmodule

// File: rtl/binary_to_str.sv
// 64 parallel byte converters feeding one registered 1536-bit text output (1-cycle latency).
module binary_to_str
    import binary_to_str_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic              CLK,
    output logic [OUT_W-1:0]  out,
    input  logic              RST
);

    logic [OUT_W-1:0] conv;

    // Byte k maps straight to group k; order is preserved end to end.
    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
        byte_to_dec3 u_conv (
            .val  (in[DATA_W-1-CHAR_W*k -: CHAR_W]),
            .ascii(conv[OUT_W-1-GROUP_W*k -: GROUP_W])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) out <= '0;
        else     out <= conv;
    end

endmodule

// File: tb/tb_binary_to_str.sv
// Self-checking bench: vector table plus sweep, with a queue scoreboard of expected outputs.
module tb_binary_to_str;

    logic [511:0]  din;
    logic          clk;
    logic [1535:0] dout;
    logic          rst;

    int checks   = 0;
    int failures = 0;
    logic [1535:0] exp_q[$];

    binary_to_str dut (.in(din), .CLK(clk), .out(dout), .RST(rst));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [511:0]  din;
        logic [1535:0] exp;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [1535:0] model(input logic [511:0] d);
        logic [1535:0] r;
        logic [7:0] v;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            v = d[511-8*k -: 8];
            r[1535-24*k -: 24] = {8'h30 + 8'(v / 100), 8'h30 + 8'((v / 10) % 10), 8'h30 + 8'(v % 10)};
        end
        return r;
    endfunction

    // One cycle: drive at negedge, push expectation, sample 1 time unit after the posedge.
    task automatic step(input logic [511:0] d, input logic r, input string name);
        logic [1535:0] e;
        int g;
        @(negedge clk);
        din = d;
        rst = r;
        exp_q.push_back(r ? 1536'b0 : model(d));
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            if (dout !== e) begin
                failures++;
                g = 0;
                for (int k = 63; k >= 0; k--)
                    if (dout[1535-24*k -: 24] !== e[1535-24*k -: 24]) g = k;
                $display("FAIL %s group %0d got=%h exp=%h", name, g,
                         dout[1535-24*g -: 24], e[1535-24*g -: 24]);
            end
        end
    endtask

    task automatic check_group(input string name, input int k, input logic [23:0] e);
        checks++;
        if (dout[1535-24*k -: 24] !== e) begin
            failures++;
            $display("FAIL %s group %0d got=%h exp=%h", name, k, dout[1535-24*k -: 24], e);
        end
    endtask

    task automatic check_range(input string name);
        int bad;
        bad = -1;
        for (int k = 0; k < 64; k++) begin
            for (int c = 0; c < 3; c++)
                if (dout[1535-24*k-8*c -: 8] < 8'h30 || dout[1535-24*k-8*c -: 8] > 8'h39) bad = k;
            if (dout[1535-24*k -: 8] > 8'h32) bad = k;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s group %0d got=%h exp=digits", name, bad, dout[1535-24*bad -: 24]);
        end
    endtask

    initial begin
        logic [511:0] d;
        logic [511:0] base;
        string s;
        din = '0;
        rst = 1'b1;

        // Reset held two cycles with arbitrary input.
        for (int k = 0; k < 16; k++) d[511-32*k -: 32] = $urandom;
        step(d, 1'b1, "reset0");
        step(d, 1'b1, "reset1");
        step(d, 1'b0, "release");
        check_range("release_range");

        s = "Hello my name is Leah ";
        for (int k = 0; k < 64; k++)
            vecs[0].din[511-8*k -: 8] = (k < s.len()) ? s[k] : 8'h2E;
        vecs[0].din[7:0] = 8'h29;
        vecs[0].name = "hello";
        vecs[1].name = "all00";
        vecs[1].din = '0;
        vecs[2].name = "allff";
        vecs[2].din = '1;
        vecs[3].name = "ramp";
        for (int k = 0; k < 64; k++) vecs[3].din[511-8*k -: 8] = 8'(k);
        vecs[4].name = "bounds";
        for (int k = 0; k < 64; k++) begin
            case (k % 4)
                0: vecs[4].din[511-8*k -: 8] = 8'h00;
                1: vecs[4].din[511-8*k -: 8] = 8'hFF;
                2: vecs[4].din[511-8*k -: 8] = 8'h64;
                default: vecs[4].din[511-8*k -: 8] = 8'h09;
            endcase
        end
        for (int i = 0; i < 5; i++) vecs[i].exp = model(vecs[i].din);

        for (int i = 0; i < 5; i++) begin
            step(vecs[i].din, 1'b0, vecs[i].name);
            checks++;
            if (dout !== vecs[i].exp) begin
                failures++;
                $display("FAIL %s_table got=%h exp=%h", vecs[i].name, dout[23:0], vecs[i].exp[23:0]);
            end
            case (i)
                0: begin
                    check_group("hello_first", 0, 24'h303732);
                    check_group("hello_last", 63, 24'h303431);
                end
                1: begin
                    checks++;
                    if (dout !== {64{24'h303030}}) begin
                        failures++;
                        $display("FAIL all00_const got=%h exp=303030", dout[23:0]);
                    end
                end
                2: begin
                    checks++;
                    if (dout !== {64{24'h323535}}) begin
                        failures++;
                        $display("FAIL allff_const got=%h exp=323535", dout[23:0]);
                    end
                end
                3: begin
                    check_group("ramp_g0", 0, 24'h303030);
                    check_group("ramp_g10", 10, 24'h303130);
                    check_group("ramp_g63", 63, 24'h303633);
                end
                default: begin
                    check_group("bound_00", 0, 24'h303030);
                    check_group("bound_ff", 1, 24'h323535);
                    check_group("bound_64", 2, 24'h313030);
                    check_group("bound_09", 3, 24'h303039);
                end
            endcase
            check_range({vecs[i].name, "_range"});
        end

        // Same input twice: still a fresh, identical conversion.
        step(vecs[3].din, 1'b0, "repeat");

        // Sweep byte 0 every cycle with the other bytes fixed; one reset pulse mid-sweep.
        for (int k = 0; k < 16; k++) base[511-32*k -: 32] = $urandom;
        for (int v = 0; v < 256; v++) begin
            d = base;
            d[511:504] = 8'(v);
            if (v == 128) begin
                step(d, 1'b1, "sweep_rst");
            end else begin
                step(d, 1'b0, "sweep");
                if (v % 32 == 0) check_range("sweep_range");
            end
        end
        step(base, 1'b0, "sweep_end");

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
